ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_sync_edge.sv | 35 +++
 rtl/ps2_key_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard decoder: FSM encoding, prefix bytes
// and the scan codes of the arrow keys.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
  localparam logic [7:0] PS2_KEY_UP    = 8'h75;
  localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;

  // A frame is good when the data byte plus its parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 clock and data lines into the clk domain and flags
// falling edges of the PS/2 clock. Idle bus level is high, so reset loads ones.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic clk_sync;
  logic clk_prev;
  logic data_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scan-code decoder (E0 / F0 prefix handling).
// Optional feature: define PS2_TIMEOUT_EN to abandon stalled partial frames.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_make,
  output logic       key_ext,
  output logic       key_valid,
  output logic       frame_err
);

  ps2_state_t state, state_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] shift, shift_next;
  logic       par_bit, par_bit_next;
  logic       ext, ext_next;
  logic       brk, brk_next;
  logic [7:0] keycode_next;
  logic       key_make_next;
  logic       key_ext_next;
  logic       key_valid_next;
  logic       frame_err_next;
  logic       data_sync;
  logic       clk_fall;
  logic       timeout_hit;

  ps2_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_sync(data_sync),
    .clk_fall (clk_fall)
  );

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Saturates at the limit so an idle bus never wraps into a false timeout.
  always_ff @(posedge clk) begin
    if (reset || clk_fall)
      to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYCLES))
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'd0;
      par_bit   <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      keycode   <= 8'd0;
      key_make  <= 1'b0;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
      par_bit   <= par_bit_next;
      ext       <= ext_next;
      brk       <= brk_next;
      keycode   <= keycode_next;
      key_make  <= key_make_next;
      key_ext   <= key_ext_next;
      key_valid <= key_valid_next;
      frame_err <= frame_err_next;
    end
  end

  // Prefixes only arm flags; any other good byte is reported and consumes them.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    par_bit_next   = par_bit;
    ext_next       = ext;
    brk_next       = brk;
    keycode_next   = keycode;
    key_make_next  = key_make;
    key_ext_next   = key_ext;
    key_valid_next = 1'b0;
    frame_err_next = 1'b0;

    if (clk_fall) begin
      case (state)
        IDLE: begin
          if (!data_sync) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end
        end
        DATA: begin
          shift_next   = {data_sync, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_next = PARITY;
        end
        PARITY: begin
          par_bit_next = data_sync;
          state_next   = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_sync && parity_ok(shift, par_bit)) begin
            if (shift == PS2_PREFIX_EXT) begin
              ext_next = 1'b1;
            end else if (shift == PS2_PREFIX_BRK) begin
              brk_next = 1'b1;
            end else begin
              keycode_next   = shift;
              key_make_next  = ~brk;
              key_ext_next   = ext;
              key_valid_next = 1'b1;
              ext_next       = 1'b0;
              brk_next       = 1'b0;
            end
          end else begin
            frame_err_next = 1'b1;
            ext_next       = 1'b0;
            brk_next       = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next     = IDLE;
      ext_next       = 1'b0;
      brk_next       = 1'b0;
      frame_err_next = 1'b1;
    end
  end

endmodule
